// File: rtl/timer_apb_sequencer_pkg.sv
// Shared definitions for the timer APB sequencer: register map, TCR fields, FSM encoding.
package timer_apb_sequencer_pkg;

   localparam logic [7:0] TDR_ADDR_DEF = 8'h00;
   localparam logic [7:0] TCR_ADDR_DEF = 8'h01;
   localparam logic [7:0] TSR_ADDR_DEF = 8'h02;

   localparam int TCR_LOAD_BIT = 7;
   localparam int TCR_DOWN_BIT = 5;
   localparam int TCR_EN_BIT   = 4;
   localparam int TCR_CLKSEL_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_TDR   = 3'd1,
      ST_WR_LOAD  = 3'd2,
      ST_WR_EN    = 3'd3,
      ST_WAIT_EVT = 3'd4,
      ST_RD_TSR   = 3'd5,
      ST_CLR_TSR  = 3'd6,
      ST_WR_STOP  = 3'd7
   } seq_state_t;

   function automatic logic [7:0] tcr_word(input logic load, input logic en,
                                           input logic down, input logic [1:0] clksel);
      logic [7:0] w;
      w = 8'h00;
      w[TCR_LOAD_BIT] = load;
      w[TCR_DOWN_BIT] = down;
      w[TCR_EN_BIT]   = en;
      w[TCR_CLKSEL_LSB +: 2] = clksel;
      return w;
   endfunction

endpackage

// File: rtl/timer_apb_sequencer_apb_master_xfer.sv
// Single APB transfer engine: SETUP, ACCESS until PREADY, then one cycle with PSEL low.
module apb_master_xfer #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  PCLK,
   input  logic                  PRESET_n,
   input  logic                  i_req,
   input  logic                  i_write,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_slverr,
   output logic                  M_PSEL,
   output logic                  M_PENABLE,
   output logic                  M_PWRITE,
   output logic [ADDR_WIDTH-1:0] M_PADDR,
   output logic [DATA_WIDTH-1:0] M_PWDATA,
   input  logic [DATA_WIDTH-1:0] M_PRDATA,
   input  logic                  M_PREADY,
   input  logic                  M_PSLVERR
);

   logic                  r_psel;
   logic                  r_penable;
   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic                  w_complete;

   assign w_complete = r_psel & r_penable & M_PREADY;

   // The idle cycle after completion falls out naturally: PSEL is only raised from a cycle where it was low.
   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
      end else if (w_complete) begin
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
      end else if (r_psel && !r_penable) begin
         r_penable <= 1'b1;
      end else if (!r_psel && i_req) begin
         r_psel   <= 1'b1;
         r_pwrite <= i_write;
         r_paddr  <= i_addr;
         r_pwdata <= i_wdata;
      end
   end

   assign o_done    = w_complete;
   assign o_rdata   = M_PRDATA;
   assign o_slverr  = M_PSLVERR;
   assign M_PSEL    = r_psel;
   assign M_PENABLE = r_penable;
   assign M_PWRITE  = r_pwrite;
   assign M_PADDR   = r_paddr;
   assign M_PWDATA  = r_pwdata;

endmodule

// File: rtl/timer_apb_sequencer.sv
// Command-driven APB master that loads, runs, services and stops the 8-bit timer.
//   state    | meaning
//   IDLE     | ready for a command
//   WR_TDR   | write reload value
//   WR_LOAD  | TCR load pulse
//   WR_EN    | TCR enable counting
//   WAIT_EVT | wait for timer event or abort
//   RD_TSR   | read status
//   CLR_TSR  | clear status, count event
//   WR_STOP  | TCR = 0, then back to IDLE
module timer_apb_sequencer
   import timer_apb_sequencer_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] TDR_ADDR   = ADDR_WIDTH'(TDR_ADDR_DEF),
   parameter logic [ADDR_WIDTH-1:0] TCR_ADDR   = ADDR_WIDTH'(TCR_ADDR_DEF),
   parameter logic [ADDR_WIDTH-1:0] TSR_ADDR   = ADDR_WIDTH'(TSR_ADDR_DEF)
) (
   input  logic                  PCLK,
   input  logic                  PRESET_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [7:0]            cmd_reload,
   input  logic                  cmd_down,
   input  logic [1:0]            cmd_clksel,
   input  logic [7:0]            cmd_periods,
   input  logic                  cmd_abort,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [7:0]            evt_cnt,
   output logic [7:0]            last_tsr,
   output logic                  M_PSEL,
   output logic                  M_PENABLE,
   output logic                  M_PWRITE,
   output logic [ADDR_WIDTH-1:0] M_PADDR,
   output logic [DATA_WIDTH-1:0] M_PWDATA,
   input  logic [DATA_WIDTH-1:0] M_PRDATA,
   input  logic                  M_PREADY,
   input  logic                  M_PSLVERR,
   input  logic                  TMR_OVF,
   input  logic                  TMR_URF
);

   seq_state_t r_state;
   logic       r_cmd_ready, r_busy, r_done, r_err;
   logic [7:0] r_evt_cnt, r_last_tsr;
   logic [7:0] r_reload, r_periods;
   logic       r_down;
   logic [1:0] r_clksel;
   logic       r_evt_q, r_evt_pending, r_abort_pending;

   logic                  w_req, w_write;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_xfer_done, w_slverr;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_evt_or, w_evt_rise;
   logic [7:0]            w_evt_next;

   assign w_evt_or   = TMR_OVF | TMR_URF;
   assign w_evt_rise = w_evt_or & ~r_evt_q;
   assign w_evt_next = (r_evt_cnt == 8'hFF) ? 8'hFF : r_evt_cnt + 8'd1;

   always_comb begin
      w_req   = 1'b0;
      w_write = 1'b1;
      w_addr  = TCR_ADDR;
      w_wdata = '0;
      case (r_state)
         ST_WR_TDR: begin
            w_req   = 1'b1;
            w_addr  = TDR_ADDR;
            w_wdata = DATA_WIDTH'(r_reload);
         end
         ST_WR_LOAD: begin
            w_req   = 1'b1;
            w_wdata = DATA_WIDTH'(tcr_word(1'b1, 1'b0, r_down, r_clksel));
         end
         ST_WR_EN: begin
            w_req   = 1'b1;
            w_wdata = DATA_WIDTH'(tcr_word(1'b0, 1'b1, r_down, r_clksel));
         end
         ST_RD_TSR: begin
            w_req   = 1'b1;
            w_write = 1'b0;
            w_addr  = TSR_ADDR;
         end
         ST_CLR_TSR: begin
            w_req   = 1'b1;
            w_addr  = TSR_ADDR;
         end
         ST_WR_STOP: w_req = 1'b1;
         default:    w_req = 1'b0;
      endcase
   end

   apb_master_xfer #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_xfer (
      .PCLK      (PCLK),
      .PRESET_n  (PRESET_n),
      .i_req     (w_req),
      .i_write   (w_write),
      .i_addr    (w_addr),
      .i_wdata   (w_wdata),
      .o_done    (w_xfer_done),
      .o_rdata   (w_rdata),
      .o_slverr  (w_slverr),
      .M_PSEL    (M_PSEL),
      .M_PENABLE (M_PENABLE),
      .M_PWRITE  (M_PWRITE),
      .M_PADDR   (M_PADDR),
      .M_PWDATA  (M_PWDATA),
      .M_PRDATA  (M_PRDATA),
      .M_PREADY  (M_PREADY),
      .M_PSLVERR (M_PSLVERR)
   );

   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         r_state         <= ST_IDLE;
         r_cmd_ready     <= 1'b1;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_err           <= 1'b0;
         r_evt_cnt       <= 8'h00;
         r_last_tsr      <= 8'h00;
         r_reload        <= 8'h00;
         r_periods       <= 8'h00;
         r_down          <= 1'b0;
         r_clksel        <= 2'b00;
         r_evt_q         <= 1'b0;
         r_evt_pending   <= 1'b0;
         r_abort_pending <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_evt_q <= w_evt_or;
         if (r_state != ST_IDLE && cmd_abort)
            r_abort_pending <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_reload        <= cmd_reload;
                  r_down          <= cmd_down;
                  r_clksel        <= cmd_clksel;
                  r_periods       <= cmd_periods;
                  r_err           <= 1'b0;
                  r_evt_cnt       <= 8'h00;
                  r_evt_pending   <= 1'b0;
                  r_abort_pending <= 1'b0;
                  r_busy          <= 1'b1;
                  r_cmd_ready     <= 1'b0;
                  r_state         <= ST_WR_TDR;
               end
            end
            ST_WR_TDR, ST_WR_LOAD, ST_WR_EN: begin
               if (w_xfer_done) begin
                  if (w_slverr) begin
                     r_err           <= 1'b1;
                     r_abort_pending <= 1'b0;
                     r_state         <= ST_WR_STOP;
                  end else if (r_state == ST_WR_TDR) begin
                     r_state <= ST_WR_LOAD;
                  end else if (r_state == ST_WR_LOAD) begin
                     r_state <= ST_WR_EN;
                  end else begin
                     r_state <= ST_WAIT_EVT;
                  end
               end
            end
            ST_WAIT_EVT: begin
               if (r_evt_pending) begin
                  r_evt_pending <= 1'b0;
                  r_state       <= ST_RD_TSR;
               end else if (cmd_abort || r_abort_pending) begin
                  r_abort_pending <= 1'b0;
                  r_state         <= ST_WR_STOP;
               end
            end
            ST_RD_TSR: begin
               if (w_xfer_done) begin
                  r_last_tsr <= 8'(w_rdata);
                  if (w_slverr) begin
                     r_err           <= 1'b1;
                     r_abort_pending <= 1'b0;
                     r_state         <= ST_WR_STOP;
                  end else begin
                     r_state <= ST_CLR_TSR;
                  end
               end
            end
            ST_CLR_TSR: begin
               if (w_xfer_done) begin
                  if (w_slverr) begin
                     r_err           <= 1'b1;
                     r_abort_pending <= 1'b0;
                     r_state         <= ST_WR_STOP;
                  end else begin
                     r_evt_cnt <= w_evt_next;
                     if ((r_periods != 8'h00 && w_evt_next == r_periods) ||
                         cmd_abort || r_abort_pending) begin
                        r_abort_pending <= 1'b0;
                        r_state         <= ST_WR_STOP;
                     end else begin
                        r_state <= ST_WAIT_EVT;
                     end
                  end
               end
            end
            ST_WR_STOP: begin
               if (w_xfer_done) begin
                  if (w_slverr)
                     r_err <= 1'b1;
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_busy      <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase

         // A new edge in the same cycle the pending flag is consumed must survive.
         if (w_evt_rise && r_state != ST_IDLE)
            r_evt_pending <= 1'b1;
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign evt_cnt   = r_evt_cnt;
   assign last_tsr  = r_last_tsr;

endmodule

// File: tb/tb_timer_apb_sequencer.sv
// Directed bench for timer_apb_sequencer with an APB completion log and hand-computed vectors.
module tb_timer_apb_sequencer;

   logic       PCLK = 1'b0;
   logic       PRESET_n;
   logic       cmd_valid, cmd_ready;
   logic [7:0] cmd_reload;
   logic       cmd_down;
   logic [1:0] cmd_clksel;
   logic [7:0] cmd_periods;
   logic       cmd_abort;
   logic       busy, done, err;
   logic [7:0] evt_cnt, last_tsr;
   logic       M_PSEL, M_PENABLE, M_PWRITE;
   logic [7:0] M_PADDR, M_PWDATA, M_PRDATA;
   logic       M_PREADY, M_PSLVERR;
   logic       TMR_OVF, TMR_URF;

   int n_vec = 0;
   int n_err = 0;
   int rd_ptr = 0;
   int log_n = 0;
   logic [16:0] log_q [0:255];

   always #5 PCLK = ~PCLK;

   timer_apb_sequencer dut (
      .PCLK        (PCLK),
      .PRESET_n    (PRESET_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_reload  (cmd_reload),
      .cmd_down    (cmd_down),
      .cmd_clksel  (cmd_clksel),
      .cmd_periods (cmd_periods),
      .cmd_abort   (cmd_abort),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .evt_cnt     (evt_cnt),
      .last_tsr    (last_tsr),
      .M_PSEL      (M_PSEL),
      .M_PENABLE   (M_PENABLE),
      .M_PWRITE    (M_PWRITE),
      .M_PADDR     (M_PADDR),
      .M_PWDATA    (M_PWDATA),
      .M_PRDATA    (M_PRDATA),
      .M_PREADY    (M_PREADY),
      .M_PSLVERR   (M_PSLVERR),
      .TMR_OVF     (TMR_OVF),
      .TMR_URF     (TMR_URF)
   );

   // Record every completed transfer as {write, addr, data}.
   always @(posedge PCLK) begin
      if (PRESET_n && M_PSEL && M_PENABLE && M_PREADY) begin
         log_q[log_n[7:0]] <= {M_PWRITE, M_PADDR, M_PWRITE ? M_PWDATA : M_PRDATA};
         log_n <= log_n + 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no end of run, expected summary before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_xfer(input string tag, input logic w, input logic [7:0] a,
                              input logic [7:0] d);
      logic [16:0] rec;
      rec = 'x;
      for (int i = 0; i < 300; i++) begin
         if (log_n > rd_ptr) begin
            rec = log_q[rd_ptr[7:0]];
            rd_ptr++;
            break;
         end
         tick();
      end
      chk(tag, {15'd0, rec}, {15'd0, w, a, d});
   endtask

   task automatic wait_done(input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (done === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk({tag, " done seen"}, {31'd0, found}, 32'd1);
      tick();
      chk({tag, " done one cycle"}, {31'd0, done}, 32'd0);
   endtask

   task automatic wait_penable(input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (M_PENABLE === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk({tag, " access reached"}, {31'd0, found}, 32'd1);
   endtask

   task automatic send_cmd(input logic [7:0] reload, input logic down,
                           input logic [1:0] clksel, input logic [7:0] periods);
      cmd_reload  = reload;
      cmd_down    = down;
      cmd_clksel  = clksel;
      cmd_periods = periods;
      cmd_valid   = 1'b1;
      tick();
      cmd_valid   = 1'b0;
      chk("accept busy", {31'd0, busy}, 32'd1);
      chk("accept cmd_ready", {31'd0, cmd_ready}, 32'd0);
   endtask

   task automatic pulse_evt(input logic urf);
      if (urf) TMR_URF = 1'b1;
      else     TMR_OVF = 1'b1;
      tick();
      TMR_OVF = 1'b0;
      TMR_URF = 1'b0;
   endtask

   initial begin
      PRESET_n    = 1'b0;
      cmd_valid   = 1'b0;
      cmd_reload  = 8'h00;
      cmd_down    = 1'b0;
      cmd_clksel  = 2'b00;
      cmd_periods = 8'h00;
      cmd_abort   = 1'b0;
      M_PRDATA    = 8'h00;
      M_PREADY    = 1'b1;
      M_PSLVERR   = 1'b0;
      TMR_OVF     = 1'b0;
      TMR_URF     = 1'b0;
      repeat (3) tick();

      chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst err", {31'd0, err}, 32'd0);
      chk("rst evt_cnt", {24'd0, evt_cnt}, 32'd0);
      chk("rst last_tsr", {24'd0, last_tsr}, 32'd0);
      chk("rst psel", {31'd0, M_PSEL}, 32'd0);
      chk("rst penable", {31'd0, M_PENABLE}, 32'd0);
      chk("rst pwrite", {31'd0, M_PWRITE}, 32'd0);
      chk("rst paddr", {24'd0, M_PADDR}, 32'd0);
      PRESET_n = 1'b1;
      tick();

      // abort while idle is ignored
      cmd_abort = 1'b1;
      tick();
      cmd_abort = 1'b0;
      tick();
      chk("idle abort busy", {31'd0, busy}, 32'd0);

      // up mode, reload FD, clksel 2, one period
      M_PRDATA = 8'h01;
      send_cmd(8'hFD, 1'b0, 2'd2, 8'd1);
      expect_xfer("t1 wr tdr", 1'b1, 8'h00, 8'hFD);
      expect_xfer("t1 wr load", 1'b1, 8'h01, 8'h82);
      expect_xfer("t1 wr en", 1'b1, 8'h01, 8'h12);
      pulse_evt(1'b0);
      expect_xfer("t1 rd tsr", 1'b0, 8'h02, 8'h01);
      expect_xfer("t1 clr tsr", 1'b1, 8'h02, 8'h00);
      expect_xfer("t1 stop", 1'b1, 8'h01, 8'h00);
      wait_done("t1");
      chk("t1 evt_cnt", {24'd0, evt_cnt}, 32'd1);
      chk("t1 err", {31'd0, err}, 32'd0);
      chk("t1 last_tsr", {24'd0, last_tsr}, 32'h01);
      chk("t1 cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("t1 busy", {31'd0, busy}, 32'd0);

      // down mode, three underflows
      M_PRDATA = 8'h02;
      send_cmd(8'h03, 1'b1, 2'd0, 8'd3);
      expect_xfer("t2 wr tdr", 1'b1, 8'h00, 8'h03);
      expect_xfer("t2 wr load", 1'b1, 8'h01, 8'hA0);
      expect_xfer("t2 wr en", 1'b1, 8'h01, 8'h30);
      for (int k = 0; k < 3; k++) begin
         pulse_evt(1'b1);
         expect_xfer("t2 rd tsr", 1'b0, 8'h02, 8'h02);
         expect_xfer("t2 clr tsr", 1'b1, 8'h02, 8'h00);
      end
      expect_xfer("t2 stop", 1'b1, 8'h01, 8'h00);
      wait_done("t2");
      chk("t2 evt_cnt", {24'd0, evt_cnt}, 32'd3);
      chk("t2 last_tsr", {24'd0, last_tsr}, 32'h02);

      // PREADY low for three cycles of the TDR access
      M_PRDATA = 8'h04;
      M_PREADY = 1'b0;
      send_cmd(8'h55, 1'b0, 2'd1, 8'd1);
      wait_penable("t3");
      for (int i = 0; i < 3; i++) begin
         chk("t3 stall penable", {31'd0, M_PENABLE}, 32'd1);
         chk("t3 stall paddr", {24'd0, M_PADDR}, 32'h00);
         chk("t3 stall pwdata", {24'd0, M_PWDATA}, 32'h55);
         chk("t3 stall no completion", log_n - rd_ptr, 32'd0);
         tick();
      end
      M_PREADY = 1'b1;
      chk("t3 fourth access cycle", {31'd0, M_PENABLE}, 32'd1);
      expect_xfer("t3 wr tdr", 1'b1, 8'h00, 8'h55);
      chk("t3 penable dropped", {31'd0, M_PENABLE}, 32'd0);
      expect_xfer("t3 wr load", 1'b1, 8'h01, 8'h81);
      expect_xfer("t3 wr en", 1'b1, 8'h01, 8'h11);
      pulse_evt(1'b0);
      expect_xfer("t3 rd tsr", 1'b0, 8'h02, 8'h04);
      expect_xfer("t3 clr tsr", 1'b1, 8'h02, 8'h00);
      expect_xfer("t3 stop", 1'b1, 8'h01, 8'h00);
      wait_done("t3");
      chk("t3 evt_cnt", {24'd0, evt_cnt}, 32'd1);

      // slave error on the load write
      send_cmd(8'h77, 1'b0, 2'd3, 8'd1);
      expect_xfer("t4 wr tdr", 1'b1, 8'h00, 8'h77);
      M_PSLVERR = 1'b1;
      expect_xfer("t4 wr load", 1'b1, 8'h01, 8'h83);
      M_PSLVERR = 1'b0;
      expect_xfer("t4 stop after slverr", 1'b1, 8'h01, 8'h00);
      wait_done("t4");
      chk("t4 err", {31'd0, err}, 32'd1);
      chk("t4 evt_cnt", {24'd0, evt_cnt}, 32'd0);
      repeat (5) tick();
      chk("t4 no enable write", log_n - rd_ptr, 32'd0);

      // free-run, busy command ignored, abort after two events
      M_PRDATA = 8'h08;
      send_cmd(8'h10, 1'b0, 2'd3, 8'd0);
      chk("t5 err cleared", {31'd0, err}, 32'd0);
      expect_xfer("t5 wr tdr", 1'b1, 8'h00, 8'h10);
      expect_xfer("t5 wr load", 1'b1, 8'h01, 8'h83);
      expect_xfer("t5 wr en", 1'b1, 8'h01, 8'h13);
      cmd_valid  = 1'b1;
      cmd_reload = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         chk("t5 busy cmd_ready", {31'd0, cmd_ready}, 32'd0);
         tick();
      end
      cmd_valid = 1'b0;
      chk("t5 busy no accept", log_n - rd_ptr, 32'd0);
      pulse_evt(1'b0);
      expect_xfer("t5 rd tsr 1", 1'b0, 8'h02, 8'h08);
      expect_xfer("t5 clr tsr 1", 1'b1, 8'h02, 8'h00);
      pulse_evt(1'b0);
      expect_xfer("t5 rd tsr 2", 1'b0, 8'h02, 8'h08);
      expect_xfer("t5 clr tsr 2", 1'b1, 8'h02, 8'h00);
      cmd_abort = 1'b1;
      tick();
      cmd_abort = 1'b0;
      expect_xfer("t5 stop", 1'b1, 8'h01, 8'h00);
      wait_done("t5");
      chk("t5 evt_cnt", {24'd0, evt_cnt}, 32'd2);

      // reset in the middle of the enable access
      send_cmd(8'h20, 1'b0, 2'd0, 8'd1);
      expect_xfer("t6 wr tdr", 1'b1, 8'h00, 8'h20);
      expect_xfer("t6 wr load", 1'b1, 8'h01, 8'h80);
      M_PREADY = 1'b0;
      wait_penable("t6");
      chk("t6 access paddr", {24'd0, M_PADDR}, 32'h01);
      chk("t6 access pwdata", {24'd0, M_PWDATA}, 32'h10);
      PRESET_n = 1'b0;
      #1;
      chk("t6 rst psel", {31'd0, M_PSEL}, 32'd0);
      chk("t6 rst penable", {31'd0, M_PENABLE}, 32'd0);
      chk("t6 rst busy", {31'd0, busy}, 32'd0);
      chk("t6 rst cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("t6 rst last_tsr", {24'd0, last_tsr}, 32'd0);
      M_PREADY = 1'b1;
      tick();
      tick();
      PRESET_n = 1'b1;
      tick();
      rd_ptr = log_n;
      M_PRDATA = 8'h10;
      send_cmd(8'h33, 1'b0, 2'd0, 8'd1);
      expect_xfer("t6 wr tdr", 1'b1, 8'h00, 8'h33);
      expect_xfer("t6 wr load", 1'b1, 8'h01, 8'h80);
      expect_xfer("t6 wr en", 1'b1, 8'h01, 8'h10);
      pulse_evt(1'b0);
      expect_xfer("t6 rd tsr", 1'b0, 8'h02, 8'h10);
      expect_xfer("t6 clr tsr", 1'b1, 8'h02, 8'h00);
      expect_xfer("t6 stop", 1'b1, 8'h01, 8'h00);
      wait_done("t6");
      chk("t6 evt_cnt", {24'd0, evt_cnt}, 32'd1);
      chk("t6 err", {31'd0, err}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/timer_apb_sequencer.md
Name: timer_apb_sequencer

Overview:
- APB master FSM that configures and runs the 8-bit timer (timer_top) on behalf of a simple command interface.
- Sequence per command: load reload value, pulse TCR.load, enable counting, then service N overflow/underflow events by reading and clearing TSR, then stop the timer.
- Sits between a host-side command source and the timer's APB slave port.
- Replaces ad-hoc register poking with one fixed, verifiable sequence.

Parameters:
- ADDR_WIDTH, 8, APB address width
- DATA_WIDTH, 8, APB data width; must be 8
- TDR_ADDR, 8'h00, timer data (reload) register address
- TCR_ADDR, 8'h01, timer control register address
- TSR_ADDR, 8'h02, timer status register address

Ports:
- PCLK  in  1  clock
- PRESET_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&cmd_ready
- cmd_reload  in  8  value written to TDR
- cmd_down  in  1  1 = count down (TCR bit5), 0 = count up
- cmd_clksel  in  2  TCR[1:0] clock select
- cmd_periods  in  8  events to service before stopping; 0 = free-run until abort
- cmd_abort  in  1  stop request, honoured in WAIT_EVT
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle pulse on return to IDLE
- err  out  1  sticky per command; set on any PSLVERR; cleared on next accept
- evt_cnt  out  8  events serviced in current/last command
- last_tsr  out  8  data of last TSR read
- M_PSEL, M_PENABLE, M_PWRITE  out  1 each  APB master controls
- M_PADDR  out  ADDR_WIDTH  APB address
- M_PWDATA  out  DATA_WIDTH  APB write data
- M_PRDATA  in  DATA_WIDTH  APB read data
- M_PREADY, M_PSLVERR  in  1 each  APB response
- TMR_OVF, TMR_URF  in  1 each  timer event levels

Behaviour:
- Reset: every output 0, except cmd_ready = 1 (IDLE); state IDLE; internal latches cleared. Reset acts immediately, including mid-transfer (M_PSEL drops asynchronously).
- TCR encoding: bit7 load, bit5 down, bit4 enable, bits1:0 clksel; all other bits written 0.
- APB transfer engine:
  - SETUP: PSEL=1, PENABLE=0, one cycle.
  - ACCESS: PENABLE=1, held with address/data/PWRITE stable until PREADY=1.
  - The transfer completes on the edge where PSEL&PENABLE&PREADY.
  - Then one idle cycle with PSEL=0. Minimum 3 cycles per transfer.
- FSM states and transitions:
  - IDLE: on accept, latch command, clear err/evt_cnt.
  - WR_TDR: write reload → WR_LOAD.
  - WR_LOAD: TCR = 0x80|down<<5|clksel → WR_EN.
  - WR_EN: TCR = 0x10|down<<5|clksel → WAIT_EVT.
  - WAIT_EVT: on pending event → RD_TSR; on cmd_abort (and no pending event) → WR_STOP. Event has priority over abort in the same cycle.
  - RD_TSR: capture M_PRDATA into last_tsr at completion → CLR_TSR.
  - CLR_TSR: write TSR = 0x00; evt_cnt += 1 (saturate at 0xFF).
    - If cmd_periods != 0 and new evt_cnt == cmd_periods → WR_STOP.
    - Otherwise → WAIT_EVT. An abort latched since WAIT_EVT → WR_STOP.
  - WR_STOP: TCR = 0x00 → IDLE, with done pulse in the cycle IDLE is entered.
- Event capture:
  - TMR_OVF|TMR_URF registered.
  - A rising edge of the OR sets evt_pending in any non-IDLE state; cleared when RD_TSR starts.
  - Edges are never lost across transfers. Multiple edges before service count as one.
- cmd_abort is latched as abort_pending in any busy state and acted on at WAIT_EVT or after CLR_TSR. abort_pending is cleared on entry to WR_STOP. Abort in IDLE is ignored.
- PSLVERR at completion of any transfer:
  - Set err.
  - If the transfer was not WR_STOP → jump to WR_STOP.
  - If it was WR_STOP → IDLE with done.
- cmd_valid while busy: ignored; cmd_ready = 0.

Decomposition:
- Shared package/defines:
  - TDR/TCR/TSR addresses
  - TCR bit positions (LOAD=7, DOWN=5, EN=4, CLKSEL=1:0)
  - FSM state encoding
- Sub-module: apb_master_xfer, a single-transfer engine with req/write/addr/wdata in and done/rdata/slverr out. The FSM drives one request per state.

Test Plan:
- Up mode, reload 0xFD, clksel 2, periods 1:
  - APB writes TDR=0xFD, TCR=0x82, TCR=0x12.
  - One TMR_OVF pulse → TSR read, TSR=0x00 write, TCR=0x00 write.
  - done=1 for one cycle, evt_cnt=1, err=0.
- Down mode, reload 0x03, periods 3, three TMR_URF pulses:
  - Enable write is TCR=0x30.
  - Three read/clear pairs, then stop; evt_cnt=3.
- PREADY forced low 3 cycles during the TDR write:
  - M_PENABLE held 4 cycles, address/data stable, no state advance.
  - Sequence then completes normally.
- PSLVERR=1 on the WR_LOAD transfer:
  - err=1, next transfer is TCR=0x00, done pulse, WR_EN never issued.
- periods 0, two OVF pulses, then cmd_abort:
  - Two service pairs, then stop write; done, evt_cnt=2.
  - cmd_valid asserted while busy → cmd_ready=0, no accept.
- PRESET_n low during the ACCESS phase of WR_EN:
  - M_PSEL/M_PENABLE/busy=0 immediately, cmd_ready=1.
  - After release, a new command runs from WR_TDR.
